// File: rtl/sum_serializer_pkg.sv
// sum_serializer_pkg
// Shared definitions for the sum serializer: default word width, frame
// length in bit periods, the transmitter state encoding and the parity
// helper used when a word is loaded into the shift register.
package sum_serializer_pkg;

    localparam int DEFAULT_SUM_W = 4;

    // start + data + parity + stop
    localparam int FRAME_BITS = DEFAULT_SUM_W + 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DEFAULT_SUM_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sum_fifo.sv
// sum_fifo
// Small synchronous FIFO buffering sum words between the adder stage and
// the serial transmitter. Full/empty come from the occupancy count; the
// pointers are log2(DEPTH) bits and wrap naturally.
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-high; empties the FIFO
//   push   - write wdata this cycle (caller guarantees not full)
//   pop    - consume the head word this cycle (caller guarantees not empty)
//   wdata  - word to write
//   rdata  - head word (combinational read)
//   count  - words currently buffered
//   full   - count == DEPTH
//   empty  - count == 0
module sum_fifo #(
    parameter int SUM_W = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [SUM_W-1:0]           wdata,
    output logic [SUM_W-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [SUM_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rptr];

    // Storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            // Simultaneous push and pop leaves the count unchanged.
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/sum_serializer.sv
// sum_serializer
// Accepts registered sum words over a valid/ready handshake, buffers them
// in sum_fifo and shifts each one out on a UART-style line:
// start (0), data LSB first, even parity, stop (1), CLKS_PER_BIT clocks
// per bit. Back-to-back frames have no idle gap between stop and start.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready is !full of the current count, so a word offered while full is
// not taken and the producer must keep it on sum_in.
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous, active-high; aborts any frame, drops words
//   sum_in     - sum word from the adder stage
//   in_valid   - sum_in is valid this cycle
//   in_ready   - FIFO can accept a word
//   tx_out     - registered serial line, idles high
//   tx_busy    - a frame is in progress (state is not IDLE)
//   fifo_count - words currently buffered
module sum_serializer
    import sum_serializer_pkg::*;
#(
    parameter int SUM_W        = DEFAULT_SUM_W,
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SUM_W-1:0]           sum_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       tx_out,
    output logic                       tx_busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int DW = $clog2(CLKS_PER_BIT);
    localparam int BW = (SUM_W > 1) ? $clog2(SUM_W) : 1;

    // Transmitter state, visible hierarchically for checkers.
    tx_state_t        state;
    logic [DW-1:0]    div;
    logic [BW-1:0]    bit_idx;
    logic [SUM_W-1:0] shreg;
    logic [SUM_W-1:0] shreg_next;
    logic             parity;

    logic             div_wrap;
    logic             push;
    logic             pop;
    logic [SUM_W-1:0] rdata;
    logic             fifo_full;
    logic             fifo_empty;

    assign div_wrap   = (div == DW'(CLKS_PER_BIT - 1));
    assign shreg_next = shreg >> 1;

    assign in_ready = !fifo_full;
    assign push     = in_valid && !fifo_full;
    // A word leaves the FIFO when a frame starts from IDLE or chains
    // directly out of the final stop-bit clock.
    assign pop      = !fifo_empty &&
                      ((state == IDLE) || (state == STOP && div_wrap));
    assign tx_busy  = (state != IDLE);

    sum_fifo #(
        .SUM_W (SUM_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (sum_in),
        .rdata (rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            div     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
            tx_out  <= 1'b1;
        end else begin
            // Divider runs only inside a frame and restarts each bit.
            if (state != IDLE && !div_wrap) div <= div + 1'b1;
            else                            div <= '0;

            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    if (pop) begin
                        shreg  <= rdata;
                        parity <= even_parity(rdata);
                        state  <= START;
                        tx_out <= 1'b0;
                    end
                end
                START: begin
                    if (div_wrap) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx_out  <= shreg[0];
                    end
                end
                DATA: begin
                    if (div_wrap) begin
                        if (bit_idx == BW'(SUM_W - 1)) begin
                            state  <= PARITY;
                            tx_out <= parity;
                        end else begin
                            shreg   <= shreg_next;
                            bit_idx <= bit_idx + 1'b1;
                            tx_out  <= shreg_next[0];
                        end
                    end
                end
                PARITY: begin
                    if (div_wrap) begin
                        state  <= STOP;
                        tx_out <= 1'b1;
                    end
                end
                STOP: begin
                    if (div_wrap) begin
                        if (pop) begin
                            shreg  <= rdata;
                            parity <= even_parity(rdata);
                            state  <= START;
                            tx_out <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            tx_out <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_serializer.sv
module tb_sum_serializer;

    localparam int SUM_W = 4;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int FRAME_CYCLES = (SUM_W + 3) * CPB;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [SUM_W-1:0] sum_in = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             tx_out;
    logic             tx_busy;
    logic [CW-1:0]    fifo_count;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    sum_serializer #(
        .SUM_W        (SUM_W),
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sum_in     (sum_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx_out     (tx_out),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    // ---------------- scoreboard state ----------------
    int               n_checks = 0;
    int               n_fail = 0;
    logic [SUM_W-1:0] exp_q[$];
    int               start_q[$];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor: decodes the serial line ----------------
    // A frame is recognised by a low level on tx_out while no frame is open;
    // each bit is sampled in the middle of its CPB-clock period.
    bit                mon_active = 1'b0;
    int                mon_cnt = 0;
    int                mon_k = 0;
    logic [SUM_W+2:0]  frame_bits;

    task automatic score_frame();
        logic [SUM_W-1:0] w;
        logic [SUM_W-1:0] got;
        got = frame_bits[SUM_W:1];
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got data %0h, required no frame", got);
        end else begin
            w = exp_q.pop_front();
            check("start_bit", int'(frame_bits[0]), 0);
            check("data", int'(got), int'(w));
            check("parity", int'(frame_bits[SUM_W+1]), $countones(w) % 2);
            check("stop_bit", int'(frame_bits[SUM_W+2]), 1);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active) begin
                if (tx_out === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                mon_cnt++;
            end
            if (mon_active && (mon_cnt % CPB) == CPB / 2) begin
                mon_k = mon_cnt / CPB;
                frame_bits[mon_k] = tx_out;
                if (mon_k == SUM_W + 2) begin
                    mon_active = 1'b0;
                    score_frame();
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; offers w, waits for in_ready, returns at the
    // negedge after the accepting edge with in_valid still high.
    task automatic push_word(input logic [SUM_W-1:0] w, output int waited);
        waited   = 0;
        sum_in   = w;
        in_valid = 1'b1;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("push_timeout", 0, 1);
        end else begin
            exp_q.push_back(w);
        end
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy || mon_active) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", int'(n < 3000), 1);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int n;
        int lows;
        int waited;

        // Reset held 3 cycles.
        repeat (3) @(negedge clk);
        check("rst_tx_out", int'(tx_out), 1);
        check("rst_count", int'(fifo_count), 0);
        reset = 1'b0;

        // Idle after reset.
        repeat (20) begin
            @(negedge clk);
            check("idle_tx_out", int'(tx_out), 1);
            check("idle_busy", int'(tx_busy), 0);
            check("idle_count", int'(fifo_count), 0);
            check("idle_ready", int'(in_ready), 1);
        end

        // Single frame of 4'hB: latency and frame length.
        push_word(4'hB, waited);
        in_valid = 1'b0;
        check("single_count_after_push", int'(fifo_count), 1);
        check("single_line_still_idle", int'(tx_out), 1);
        @(negedge clk);
        check("single_start_low", int'(tx_out), 0);
        check("single_busy", int'(tx_busy), 1);
        check("single_count_after_pop", int'(fifo_count), 0);
        n = 0;
        while (tx_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("single_busy_len", n, FRAME_CYCLES);
        wait_drain();

        // Parity corner words.
        push_word(4'h0, waited);
        push_word(4'hF, waited);
        push_word(4'h7, waited);
        in_valid = 1'b0;
        wait_drain();

        // Fill, back-pressure and push coinciding with the chained pop.
        start_q.delete();
        for (int i = 1; i <= 5; i++) push_word(SUM_W'(i), waited);
        check("fill_count", int'(fifo_count), DEPTH);
        check("fill_ready_low", int'(in_ready), 0);
        push_word(4'h6, waited);
        in_valid = 1'b0;
        check("bp_waited", int'(waited > 0), 1);
        check("bp_count_restored", int'(fifo_count), DEPTH);
        wait_drain();
        check("b2b_frames", start_q.size(), 6);
        for (int i = 1; i < start_q.size(); i++)
            check("b2b_gap", start_q[i] - start_q[i-1], FRAME_CYCLES);

        // Randomized traffic with random gaps.
        for (int i = 0; i < 12; i++) begin
            w = $urandom_range(0, 15);
            push_word(SUM_W'(w), waited);
            in_valid = 1'b0;
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        wait_drain();

        // Reset in the middle of a frame.
        push_word(4'hA, waited);
        push_word(4'h3, waited);
        push_word(4'h5, waited);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_count_before", int'(fifo_count), 2);
        check("mid_busy_before", int'(tx_busy), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_tx_out", int'(tx_out), 1);
        check("mid_rst_count", int'(fifo_count), 0);
        check("mid_rst_busy", int'(tx_busy), 0);
        check("mid_rst_ready", int'(in_ready), 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        lows = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        check("post_reset_quiet", lows, 0);

        check("all_words_sent", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_serializer.md
Name: sum_serializer

Overview:
Downstream consumer of the nibble adder stage. Accepts each registered 4-bit sum with a valid/ready handshake and buffers it in a small FIFO. Each word is shifted out on a single-wire UART-style serial line (start, data LSB-first, even parity, stop) for off-chip observation through a dedicated output pin. Paces the bit rate with an internal clock divider.

Parameters:
SUM_W, 4, width of one sum word (matches adder result width)
DEPTH, 4, FIFO entries; power of two, at least 2
CLKS_PER_BIT, 4, clk cycles per serial bit; at least 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sum_in  in  SUM_W  sum word from adder stage
in_valid  in  1  sum_in valid this cycle
in_ready  out  1  FIFO can accept; equals not full (combinational from count)
tx_out  out  1  serial line; idles high
tx_busy  out  1  high while a frame is in progress (any state but IDLE)
fifo_count  out  clog2(DEPTH+1)  words currently buffered

Behaviour:
- Interface decision: one clock `clk`; `reset` is asynchronous and active-high. All state is cleared immediately on `reset` assertion.
- Reset values: tx_out=1, tx_busy=0, fifo_count=0, in_ready=1, FSM=IDLE, divider=0, bit index=0.
- Push: when in_valid && in_ready at a rising edge, sum_in is written and count increments. in_valid while full is ignored; the word is dropped and the producer must hold it.
- Pop: happens only when the FSM leaves IDLE, or leaves STOP with the FIFO non-empty. The popped word is latched into a SUM_W shift register and parity = XOR of its bits.
- Simultaneous push and pop: count unchanged, both take effect. A push can never coincide with full-plus-pop, because in_ready is computed before the pop.
- FSM states: IDLE, START, DATA, PARITY, STOP. Divider counts 0..CLKS_PER_BIT-1; a state advances when the divider wraps.
  - IDLE: tx_out=1. If count>0, pop and go to START at the next edge.
  - START: tx_out=0 for CLKS_PER_BIT cycles.
  - DATA: tx_out=shreg[0]. Shift right each bit period; SUM_W bits, LSB first.
  - PARITY: tx_out=even parity bit.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles. Then go to START with a pop if count>0, else IDLE. There is no idle gap between back-to-back frames.
- tx_out is a registered output.
- Latency: push at edge E into an empty FIFO in IDLE → fifo_count=1 after E → pop at E+1 → tx_out=0 from E+1. Frame length is (SUM_W+3)*CLKS_PER_BIT cycles.
- Pointer wrap-around: read and write pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from count.
- Reset mid-frame: the frame is aborted, tx_out returns to 1 in the same cycle (async), and buffered words are discarded.
- Words are serialized in push order; none are duplicated.

Decomposition:
- Shared package sum_serializer_pkg holds:
  - SUM_W default
  - FRAME_BITS = SUM_W+3
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - a function for even parity of a SUM_W vector
- One natural sub-module: sum_fifo (synchronous FIFO with parameters SUM_W and DEPTH; ports push, pop, wdata, rdata, count, full, empty; asynchronous active-high reset). The FSM, divider and shift register stay in the top.

Test Plan:
- Reset idle: hold reset 3 cycles, release, run 20 cycles with no valid → tx_out=1, tx_busy=0, fifo_count=0, in_ready=1 throughout.
- Single frame: push 4'hB with CLKS_PER_BIT=4 → tx_out=0 on the next cycle. Sampled mid-bit, the sequence is 0,1,1,0,1,1(parity),1(stop), each bit lasting 4 cycles, and tx_busy falls 28 cycles after the start.
- Parity check: push 4'h0 then 4'hF → parity bits 0 and 0. Push 4'h7 → parity 1.
- Fill and back-pressure: push 4'h1..4'h6 on consecutive cycles with in_valid held → 4'h1 pops immediately, 4'h2..4'h5 fill the FIFO, and in_ready drops. The bench holds 4'h6 until in_ready rises. Frames emerge back-to-back in order 1,2,3,4,5,6 with the stop bit directly followed by the next start bit.
- Simultaneous push/pop: with count=4, in the cycle a STOP→START pop occurs, in_ready is 0. Next cycle in_ready=1; push → count returns to 4 and no word is lost.
- Reset mid-frame: assert reset during the DATA state of 4'hA with 2 words queued → tx_out=1 in the same cycle, fifo_count=0. After release, no frame is emitted within 40 cycles.
